// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer
//   Walks one image frame through an external pixel_operator. An accepted
//   start latches the operator configuration, then the block issues one read
//   per cycle to the input image RAM. It forwards each returned byte to the
//   operator and writes each operator result to the output image RAM at the
//   address it was read from.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   start, abort         one-cycle command pulses
//   pause                level, holds read issue while high in RUN
//   cfg_select/threshold/value   operator configuration, sampled at start
//   rd_en, rd_addr, rd_data      input RAM read port
//   op_inbyte, op_select, op_threshold, op_value, op_outbyte
//                        connection to pixel_operator
//   wr_en, wr_addr, wr_data      output RAM write port
//   busy, done, pixel_count      frame status
module pixel_frame_sequencer #(
  parameter int NUM_PIXELS = 98304,
  parameter int ADDR_W     = 17,
  parameter int RD_LATENCY = 1,
  parameter int OP_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic [1:0]        cfg_select,
  input  logic [7:0]        cfg_threshold,
  input  logic [7:0]        cfg_value,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        op_inbyte,
  output logic [1:0]        op_select,
  output logic [7:0]        op_threshold,
  output logic [7:0]        op_value,
  input  logic [7:0]        op_outbyte,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   pixel_count
);

  // Total cycles between a read strobe and its operator result appearing.
  localparam int L = RD_LATENCY + OP_LATENCY;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(NUM_PIXELS - 1);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W:0]   addr_cnt;
  logic [L-1:0]      pipe_v;
  logic [ADDR_W-1:0] pipe_a [L];
  logic              abort_hit;

  // abort only means something while a frame is actually in flight
  assign abort_hit = abort && ((state == RUN) || (state == DRAIN));

  assign op_inbyte = rd_data;

  // Frame FSM plus the valid/address tracking pipeline. The pipeline follows
  // each read strobe through the RAM and operator latencies so the write can
  // be issued with the original address when the operator result arrives.
  // The FSM section comes last so an accepted start overrides pixel_count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_cnt     <= '0;
      rd_en        <= 1'b0;
      rd_addr      <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pixel_count  <= '0;
      op_select    <= '0;
      op_threshold <= '0;
      op_value     <= '0;
      pipe_v       <= '0;
      for (int i = 0; i < L; i++) pipe_a[i] <= '0;
    end else begin
      pipe_a[0] <= rd_addr;
      for (int i = 1; i < L; i++) pipe_a[i] <= pipe_a[i-1];

      if (abort_hit) begin
        pipe_v <= '0;
        wr_en  <= 1'b0;
      end else begin
        pipe_v[0] <= rd_en;
        for (int i = 1; i < L; i++) pipe_v[i] <= pipe_v[i-1];
        wr_en <= pipe_v[L-1];
        if (pipe_v[L-1]) begin
          wr_addr     <= pipe_a[L-1];
          wr_data     <= op_outbyte;
          pixel_count <= pixel_count + CNT_ONE;
        end
      end

      case (state)
        IDLE: begin
          rd_en <= 1'b0;
          done  <= 1'b0;
          if (start && !abort) begin
            op_select    <= cfg_select;
            op_threshold <= cfg_threshold;
            op_value     <= cfg_value;
            addr_cnt     <= '0;
            pixel_count  <= '0;
            busy         <= 1'b1;
            state        <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            rd_en <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (!pause) begin
            rd_en    <= 1'b1;
            rd_addr  <= addr_cnt[ADDR_W-1:0];
            addr_cnt <= addr_cnt + CNT_ONE;
            if (addr_cnt == LAST_ADDR) state <= DRAIN;
          end else begin
            rd_en <= 1'b0;
          end
        end

        DRAIN: begin
          rd_en <= 1'b0;
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (!rd_en && (pipe_v == '0)) begin
            // the final write was registered on the previous edge
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end

        DONE: begin
          rd_en <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
